// File: rtl/inst_fetch_ctrl.sv
// Credit-based fetch pacing, in-order dual issue and flush recovery for the dual-bank instruction buffer.
// Optional performance counters are compiled in when IFC_PERF_CNT_EN is defined.
module inst_fetch_ctrl #(
    parameter int DEPTH        = 128,
    parameter int MAX_INFLIGHT = 4,
    parameter int REFILL_GAP   = 2,
    localparam int OW          = $clog2(DEPTH) + 1,
    localparam int IW          = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall,
    input  logic          pause,
    input  logic          icache_ready,
    input  logic [1:0]    resp_valid,
    input  logic [1:0]    backend_ready,
    output logic [1:0]    icache_fetch_inst_en,
    output logic [1:0]    send_inst_en,
    output logic          buf_flush,
    output logic [OW-1:0] occ0,
    output logic [OW-1:0] occ1,
    output logic [IW-1:0] inflight,
    output logic [1:0]    state,
    output logic          resp_err
`ifdef IFC_PERF_CNT_EN
   ,output logic [31:0]   perf_fetch_block,
    output logic [31:0]   perf_issue_bubble
`endif
);

    localparam int SW = ((OW > IW) ? OW : IW) + 1;
    localparam int GW = $clog2(REFILL_GAP + 1) + 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] occ0_q, occ0_d;
    logic [OW-1:0] occ1_q, occ1_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          resp_err_q, resp_err_d;

    logic          in_run;
    logic          issue_gate;
    logic          credit0, credit1;
    logic          fetch_ok;
    logic          send0, send1;
    logic          resp_any, resp_hit;
    logic          push0, push1;
    logic [SW-1:0] sum0, sum1;
    logic [IW-1:0] inflight_upd;

    // Every combinational output is qualified by rst so the block is silent
    // during reset, even though flush/icache_ready may still be toggling.
    always_comb begin
        in_run     = (state_q == ST_RUN);
        issue_gate = rst && in_run && !flush && !stall && !pause;

        sum0    = SW'(occ0_q) + SW'(inflight_q);
        sum1    = SW'(occ1_q) + SW'(inflight_q);
        credit0 = (sum0 < SW'(DEPTH));
        credit1 = (sum1 < SW'(DEPTH));

        fetch_ok = issue_gate && icache_ready
                && (inflight_q < IW'(MAX_INFLIGHT)) && credit0 && credit1;

        send0 = issue_gate && (occ0_q != '0) && backend_ready[0];
        send1 = issue_gate && (occ1_q != '0) && backend_ready[1] && send0;

        resp_any = |resp_valid;
        resp_hit = resp_any && (inflight_q != '0);
        push0    = resp_valid[0] && resp_hit;
        push1    = resp_valid[1] && resp_hit;

        inflight_upd = inflight_q + IW'(fetch_ok) - IW'(resp_hit);
    end

    assign icache_fetch_inst_en = {2{fetch_ok}};
    assign send_inst_en         = {send1, send0};
    assign buf_flush            = rst && (flush || (state_q == ST_DRAIN));
    assign occ0                 = occ0_q;
    assign occ1                 = occ1_q;
    assign inflight             = inflight_q;
    assign state                = state_q;
    assign resp_err             = resp_err_q;

    // NOTE: every _d signal gets a default at the top so no path through the
    // case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        occ0_d     = occ0_q;
        occ1_d     = occ1_q;
        inflight_d = inflight_upd;
        gap_cnt_d  = gap_cnt_q;
        resp_err_d = resp_err_q || (resp_any && (inflight_q == '0));

        unique case (state_q)
            ST_RUN: begin
                if (flush) begin
                    occ0_d = '0;
                    occ1_d = '0;
                    if (inflight_upd != '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d   = ST_REFILL;
                        gap_cnt_d = GW'(REFILL_GAP);
                    end
                end else begin
                    occ0_d = occ0_q + OW'(push0) - OW'(send0);
                    occ1_d = occ1_q + OW'(push1) - OW'(send1);
                end
            end
            ST_DRAIN: begin
                occ0_d = '0;
                occ1_d = '0;
                if (inflight_upd == '0) begin
                    state_d   = ST_REFILL;
                    gap_cnt_d = GW'(REFILL_GAP);
                end
            end
            ST_REFILL: begin
                occ0_d = '0;
                occ1_d = '0;
                // A gap of 0 or 1 both leave after a single REFILL cycle.
                if (flush) begin
                    gap_cnt_d = GW'(REFILL_GAP);
                end else if (gap_cnt_q <= GW'(1)) begin
                    state_d   = ST_RUN;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                occ0_d     = '0;
                occ1_d     = '0;
                inflight_d = '0;
                gap_cnt_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            occ0_q     <= '0;
            occ1_q     <= '0;
            inflight_q <= '0;
            gap_cnt_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ0_q     <= occ0_d;
            occ1_q     <= occ1_d;
            inflight_q <= inflight_d;
            gap_cnt_q  <= gap_cnt_d;
            resp_err_q <= resp_err_d;
        end
    end

`ifdef IFC_PERF_CNT_EN
    logic [31:0] perf_fetch_block_q, perf_fetch_block_d;
    logic [31:0] perf_issue_bubble_q, perf_issue_bubble_d;

    always_comb begin
        perf_fetch_block_d  = perf_fetch_block_q;
        perf_issue_bubble_d = perf_issue_bubble_q;
        if (in_run && !stall && !pause && icache_ready && !fetch_ok
            && (perf_fetch_block_q != 32'hFFFF_FFFF)) begin
            perf_fetch_block_d = perf_fetch_block_q + 32'd1;
        end
        if (in_run && backend_ready[0] && (occ0_q == '0)
            && (perf_issue_bubble_q != 32'hFFFF_FFFF)) begin
            perf_issue_bubble_d = perf_issue_bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_block_q  <= '0;
            perf_issue_bubble_q <= '0;
        end else begin
            perf_fetch_block_q  <= perf_fetch_block_d;
            perf_issue_bubble_q <= perf_issue_bubble_d;
        end
    end

    assign perf_fetch_block  = perf_fetch_block_q;
    assign perf_issue_bubble = perf_issue_bubble_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with DEPTH=4 so the credit limit is reachable in a few cycles.
module tb_inst_fetch_ctrl;

    localparam int DEPTH = 4;
    localparam int MAXI  = 4;
    localparam int GAP   = 2;
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int IW    = $clog2(MAXI) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, stall, pause, icache_ready;
    logic [1:0]    resp_valid, backend_ready;
    logic [1:0]    icache_fetch_inst_en, send_inst_en;
    logic          buf_flush;
    logic [OW-1:0] occ0, occ1;
    logic [IW-1:0] inflight;
    logic [1:0]    state;
    logic          resp_err;
`ifdef IFC_PERF_CNT_EN
    logic [31:0]   perf_fetch_block, perf_issue_bubble;
`endif

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .REFILL_GAP(GAP)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .stall                (stall),
        .pause                (pause),
        .icache_ready         (icache_ready),
        .resp_valid           (resp_valid),
        .backend_ready        (backend_ready),
        .icache_fetch_inst_en (icache_fetch_inst_en),
        .send_inst_en         (send_inst_en),
        .buf_flush            (buf_flush),
        .occ0                 (occ0),
        .occ1                 (occ1),
        .inflight             (inflight),
        .state                (state),
        .resp_err             (resp_err)
`ifdef IFC_PERF_CNT_EN
       ,.perf_fetch_block     (perf_fetch_block),
        .perf_issue_bubble    (perf_issue_bubble)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle: check combinational outputs, clock, then check registered state.
    task automatic cyc(input string tag,
                       input logic fl, input logic st, input logic pa, input logic icr,
                       input logic [1:0] rv, input logic [1:0] br,
                       input logic [1:0] e_fetch, input logic [1:0] e_send, input logic e_bf,
                       input int e_o0, input int e_o1, input int e_inf, input int e_st);
        flush = fl; stall = st; pause = pa; icache_ready = icr;
        resp_valid = rv; backend_ready = br;
        #1;
        check({tag, " fetch_en"},  32'(icache_fetch_inst_en), 32'(e_fetch));
        check({tag, " send_en"},   32'(send_inst_en),         32'(e_send));
        check({tag, " buf_flush"}, 32'(buf_flush),            32'(e_bf));
        @(posedge clk);
        #1;
        check({tag, " occ0"},     32'(occ0),     32'(e_o0));
        check({tag, " occ1"},     32'(occ1),     32'(e_o1));
        check({tag, " inflight"}, 32'(inflight), 32'(e_inf));
        check({tag, " state"},    32'(state),    32'(e_st));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " fetch_en"},  32'(icache_fetch_inst_en), 32'd0);
        check({tag, " send_en"},   32'(send_inst_en),         32'd0);
        check({tag, " buf_flush"}, 32'(buf_flush),            32'd0);
        check({tag, " occ0"},      32'(occ0),                 32'd0);
        check({tag, " occ1"},      32'(occ1),                 32'd0);
        check({tag, " inflight"},  32'(inflight),             32'd0);
        check({tag, " state"},     32'(state),                32'd0);
        check({tag, " resp_err"},  32'(resp_err),             32'd0);
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b1; stall = 1'b0; pause = 1'b0; icache_ready = 1'b1;
        resp_valid = 2'b00; backend_ready = 2'b11;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b0; backend_ready = 2'b00;
        rst = 1'b1;

        // Credit limit: fill both banks to DEPTH with no issue.
        //   tag    fl st pa icr resp   br     fetch  send   bf  o0 o1 inf st
        cyc("p1a", 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1, 0);
        cyc("p1b", 0, 0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 0, 1, 1, 1, 0);
        cyc("p1c", 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 0);
        cyc("p1d", 0, 0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2, 2, 1, 0);
        cyc("p1e", 0, 0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 0, 3, 3, 1, 0);
        cyc("p1f", 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 4, 4, 0, 0);
        cyc("p1g", 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4, 4, 0, 0);

        // Issue: pause blocks, then drain to occ0=1/occ1=2 and check in-order pairing.
        cyc("p2a", 0, 0, 1, 0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 4, 4, 0, 0);
        cyc("p2b", 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b11, 0, 3, 3, 0, 0);
        cyc("p2c", 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b11, 0, 2, 2, 0, 0);
        cyc("p2d", 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 0, 1, 2, 0, 0);
        cyc("p2e", 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b11, 0, 0, 1, 0, 0);
        cyc("p2f", 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 1, 0, 0);

        // Same-cycle fetch+response and push+pop, issue at occ0==1.
        cyc("p3a", 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 1, 1, 0);
        cyc("p3b", 0, 0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 1, 2, 0, 0);
        cyc("p3c", 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 1, 2, 1, 0);
        cyc("p3d", 0, 0, 0, 1, 2'b11, 2'b11, 2'b11, 2'b11, 0, 1, 2, 1, 0);

        // Build up three outstanding pairs with occ0=occ1=1.
        cyc("p4a", 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b11, 0, 0, 1, 1, 0);
        cyc("p4b", 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 1, 2, 0);
        cyc("p4c", 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 1, 3, 0);
        cyc("p4d", 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 3, 0);
        cyc("p4e", 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 1, 2, 0);
        cyc("p4f", 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 1, 1, 3, 0);

        // Flush with inflight=3: DRAIN for three responses, REFILL two cycles, RUN.
        cyc("f0",  1, 0, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0, 3, 1);
        cyc("d1",  0, 0, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0, 3, 1);
        cyc("d2",  0, 0, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0, 2, 1);
        cyc("d3",  0, 0, 0, 1, 2'b10, 2'b11, 2'b00, 2'b00, 1, 0, 0, 1, 1);
        cyc("d4",  0, 0, 0, 1, 2'b01, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 2);
        cyc("r1",  0, 0, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2);
        cyc("r2",  0, 0, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        cyc("run1",0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1, 0);
        cyc("run2",0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0);

        // Flush beats fetch_ok and issue; a second flush in REFILL restarts the gap.
        cyc("ff",  1, 0, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 2);
        cyc("rr1", 1, 0, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 2);
        cyc("rr2", 0, 0, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2);
        cyc("rr3", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        check("resp_err before spurious", 32'(resp_err), 32'd0);

        // Spurious response at inflight=0.
        cyc("sp1", 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        check("resp_err set", 32'(resp_err), 32'd1);
        cyc("sp2", 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        check("resp_err sticky", 32'(resp_err), 32'd1);

        // Asynchronous reset in the middle of traffic.
        cyc("mid", 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1, 0);
        icache_ready = 1'b1; backend_ready = 2'b11; flush = 1'b0;
        #1;
        check("pre-reset fetch_en", 32'(icache_fetch_inst_en), 32'h3);
        rst = 1'b0;
        flush = 1'b1;
        #1;
        check_all_zero("mid reset");
`ifdef IFC_PERF_CNT_EN
        check("perf_fetch_block reset",  perf_fetch_block,  32'd0);
        check("perf_issue_bubble reset", perf_issue_bubble, 32'd0);
`endif
        @(posedge clk);
        #1;
        flush = 1'b0;
        rst = 1'b1;

        // Refill to the credit limit, then hold with icache_ready high.
        cyc("q0", 0, 0, 0, 1, 2'b00, 2'b01, 2'b11, 2'b00, 0, 0, 0, 1, 0);
        cyc("q1", 0, 0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 0, 1, 1, 1, 0);
        cyc("q2", 0, 0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2, 2, 1, 0);
        cyc("q3", 0, 0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 0, 3, 3, 1, 0);
        cyc("q4", 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 4, 4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("q%0d", 5 + i), 0, 0, 0, 1, 2'b00, 2'b00,
                2'b00, 2'b00, 0, 4, 4, 0, 0);
        end
`ifdef IFC_PERF_CNT_EN
        check("perf_fetch_block",  perf_fetch_block,  32'd5);
        check("perf_issue_bubble", perf_issue_bubble, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Credit-based controller for the dual-bank instruction buffer. It paces the icache fetch enables so the buffer can never overflow. It schedules in-order dual issue out of the two banks toward if_id, and sequences flush recovery so that responses still in flight after a redirect are discarded. It sits between the BPU/icache fetch path and the instruction buffer, and drives that buffer's fetch, pop and flush controls.

## Interface
- DEPTH, 128: entries per buffer bank.
- MAX_INFLIGHT, 4: maximum outstanding fetch pairs (requests issued, response not yet returned).
- REFILL_GAP, 2: idle cycles after a drain before fetch is re-enabled.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset; asserted at 0.
- flush  in  1  pipeline redirect.
- stall  in  1  front-end stall; blocks both fetch and issue.
- pause  in  1  back-end pause; blocks both fetch and issue.
- icache_ready  in  1  icache accepts a request this cycle.
- resp_valid  in  2  icache response for bank i; on the next edge it is pushed into bank i.
- backend_ready  in  2  if_id slot i can accept an instruction.
- icache_fetch_inst_en  out  2  fetch request; always 2'b11 or 2'b00.
- send_inst_en  out  2  pop/issue enable per bank.
- buf_flush  out  1  flush to the buffer FIFOs.
- occ0, occ1  out  $clog2(DEPTH)+1  tracked occupancy per bank.
- inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding fetch pairs.
- state  out  2  FSM state encoding: RUN=0, DRAIN=1, REFILL=2.
- resp_err  out  1  sticky; set by a response that arrives while inflight==0.

## Operation
- **fetch_ok**: state==RUN, !stall, !pause, icache_ready, inflight<MAX_INFLIGHT, and (occ_i + inflight) < DEPTH for both banks.
- **icache_fetch_inst_en** = {2{fetch_ok}}.
- **send_inst_en[0]**: state==RUN, !stall, !pause, occ0!=0, backend_ready[0].
- **send_inst_en[1]**: same conditions with bank 1, AND send_inst_en[0]. Slot 1 never issues alone, which keeps issue in order.
- **Occupancy**, in RUN: occ_i += resp_valid[i] (only when counted) − send_inst_en[i].
  - A response is counted only if inflight!=0.
  - An uncounted response sets resp_err and leaves occ unchanged.
- **In-flight count**: inflight += fetch_ok − (|resp_valid counted).
  - One pair response decrements by 1, even if only one bank's resp_valid bit is set.
- **FSM**
  - RUN → DRAIN on flush when inflight (after this cycle's update) > 0; otherwise RUN → REFILL. Flush clears occ0/occ1.
  - DRAIN: fetch and issue are blocked, buf_flush=1, and each response decrements inflight without being counted. When inflight reaches 0, load gap_cnt=REFILL_GAP and go to REFILL.
  - REFILL: fetch and issue are blocked, buf_flush=0, gap_cnt decrements each cycle; at 0 go to RUN. A REFILL_GAP of 0 passes through REFILL in one cycle.
  - A flush in DRAIN or REFILL restarts that state's sequence.
- **buf_flush** = flush | (state==DRAIN).
- **Counter widths** never wrap.
  - The fetch_ok credit check guarantees occ_i ≤ DEPTH.
  - Issue is gated on occ_i != 0, so occ_i never goes below 0.

## Timing
- Reset values:
  - Every output is 0.
  - state=RUN, occ0=occ1=0, inflight=0, gap_cnt=0, resp_err=0.
- All outputs are combinational from registered state plus same-cycle inputs; there is zero cycle of added latency.
- Counters and FSM update on the rising edge. Reset asserted mid-operation clears everything immediately (asynchronously).
- Fetch and response in the same cycle: inflight is unchanged.
- Push and pop on the same bank in the same cycle: occ is unchanged.
- Issue is allowed at occ_i==1 when that bank's response arrives the same cycle; the issued entry is the old head.
- Flush has priority over a same-cycle fetch_ok and send_inst_en: both are forced to 0 in the flush cycle.

## Configuration
- **IFC_PERF_CNT_EN defined**:
  - Adds 32-bit outputs perf_fetch_block and perf_issue_bubble, reset to 0.
  - perf_fetch_block increments each RUN cycle where !stall, !pause, icache_ready and !fetch_ok.
  - perf_issue_bubble increments each RUN cycle where backend_ready[0] && occ0==0.
  - Both saturate at 32'hFFFF_FFFF.
- **Undefined**: these ports are absent and the FSM and counters behave identically.

## Test plan
- **Reset**: rst=0 mid-traffic → all outputs 0 the same cycle; after release, state=0, occ=0.
- **Credit limit**, DEPTH=4, backend_ready=0, continuous responses → fetch stops when occ+inflight=4; occ0=occ1=4; no overflow.
- **In-order issue**: occ0=1, occ1=2, backend_ready=2'b11 → send_inst_en=2'b11, then 2'b00; occ1=1, so slot 1 is not issued without slot 0.
- **Flush with inflight=3**:
  - DRAIN for exactly 3 responses with buf_flush=1.
  - Then REFILL for 2 cycles, then RUN.
  - occ remains 0 throughout.
- **Spurious response** resp_valid=2'b01 at inflight=0 → resp_err=1 (sticky); occ0 stays 0.
- **IFC_PERF_CNT_EN**: 5 credit-blocked cycles → perf_fetch_block=5.
